// File: rtl/cplx_addsub_pipe_if.sv
// Handshake and data bundle for the complex add/subtract butterfly core.
// The master side produces A/B pairs and consumes sum/difference results.
interface cplx_addsub_pipe_if #(
   parameter int W     = 16,
   parameter int TAG_W = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic signed [W-1:0]  a_re;
   logic signed [W-1:0]  a_im;
   logic signed [W-1:0]  b_re;
   logic signed [W-1:0]  b_im;
   logic                 scale;
   logic [TAG_W-1:0]     tag_in;

   logic                 out_valid;
   logic                 out_ready;
   logic signed [W:0]    sum_re;
   logic signed [W:0]    sum_im;
   logic signed [W:0]    dif_re;
   logic signed [W:0]    dif_im;
   logic [TAG_W-1:0]     tag_out;

   modport master (
      output in_valid, a_re, a_im, b_re, b_im, scale, tag_in, out_ready,
      input  in_ready, out_valid, sum_re, sum_im, dif_re, dif_im, tag_out
   );

   modport slave (
      input  in_valid, a_re, a_im, b_re, b_im, scale, tag_in, out_ready,
      output in_ready, out_valid, sum_re, sum_im, dif_re, dif_im, tag_out
   );
endinterface

// File: rtl/cplx_addsub_pipe.sv
// Two-stage pipelined radix-2 butterfly: returns A+B and A-B, optionally halved
// with round-half-up. S1 holds full-precision results, S2 the scaled outputs.
module cplx_addsub_pipe #(
   parameter int W     = 16,
   parameter int TAG_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   cplx_addsub_pipe_if.slave   bus
);
   localparam int RW = W + 1;

   // (x + 1) >>> 1 equals (x >>> 1) + lsb, which never needs the extra guard bit.
   function automatic logic signed [RW-1:0] half_round(
      input logic signed [RW-1:0] x,
      input logic                 s
   );
      logic signed [RW-1:0] h;
      h = {x[RW-1], x[RW-1:1]} + {{(RW-1){1'b0}}, x[0]};
      return s ? h : x;
   endfunction

   logic                s1_valid;
   logic                s2_valid;
   logic                s1_load;
   logic                s2_load;

   logic signed [RW-1:0] a_re_x;
   logic signed [RW-1:0] a_im_x;
   logic signed [RW-1:0] b_re_x;
   logic signed [RW-1:0] b_im_x;

   logic signed [RW-1:0] s1_sum_re;
   logic signed [RW-1:0] s1_sum_im;
   logic signed [RW-1:0] s1_dif_re;
   logic signed [RW-1:0] s1_dif_im;
   logic                 s1_scale;
   logic [TAG_W-1:0]     s1_tag;

   logic signed [RW-1:0] s2_sum_re;
   logic signed [RW-1:0] s2_sum_im;
   logic signed [RW-1:0] s2_dif_re;
   logic signed [RW-1:0] s2_dif_im;
   logic [TAG_W-1:0]     s2_tag;

   assign s2_load = !s2_valid || bus.out_ready;
   assign s1_load = !s1_valid || s2_load;

   // Equivalent to s1_load; a full stall needs both stages occupied.
   assign bus.in_ready = !s1_valid || !s2_valid || bus.out_ready;

   assign a_re_x = {bus.a_re[W-1], bus.a_re};
   assign a_im_x = {bus.a_im[W-1], bus.a_im};
   assign b_re_x = {bus.b_re[W-1], bus.b_re};
   assign b_im_x = {bus.b_im[W-1], bus.b_im};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_sum_re <= '0;
         s1_sum_im <= '0;
         s1_dif_re <= '0;
         s1_dif_im <= '0;
         s1_scale  <= 1'b0;
         s1_tag    <= '0;
      end else if (s1_load) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_sum_re <= a_re_x + b_re_x;
            s1_sum_im <= a_im_x + b_im_x;
            s1_dif_re <= a_re_x - b_re_x;
            s1_dif_im <= a_im_x - b_im_x;
            s1_scale  <= bus.scale;
            s1_tag    <= bus.tag_in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         s2_sum_re <= '0;
         s2_sum_im <= '0;
         s2_dif_re <= '0;
         s2_dif_im <= '0;
         s2_tag    <= '0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_sum_re <= half_round(s1_sum_re, s1_scale);
            s2_sum_im <= half_round(s1_sum_im, s1_scale);
            s2_dif_re <= half_round(s1_dif_re, s1_scale);
            s2_dif_im <= half_round(s1_dif_im, s1_scale);
            s2_tag    <= s1_tag;
         end
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.sum_re    = s2_sum_re;
   assign bus.sum_im    = s2_sum_im;
   assign bus.dif_re    = s2_dif_re;
   assign bus.dif_im    = s2_dif_im;
   assign bus.tag_out   = s2_tag;
endmodule

// File: tb/tb_cplx_addsub_pipe.sv
// Directed and scoreboarded checks of the butterfly pipeline at W=2 and W=16.
module tb_cplx_addsub_pipe;
   logic clk;
   logic rst_n;

   int checks = 0;
   int errors = 0;

   cplx_addsub_pipe_if #(.W(2),  .TAG_W(4)) bus2  ();
   cplx_addsub_pipe_if #(.W(16), .TAG_W(4)) bus16 ();

   cplx_addsub_pipe #(.W(2),  .TAG_W(4)) dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
   cplx_addsub_pipe #(.W(16), .TAG_W(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic signed [15:0] a_re;
      logic signed [15:0] a_im;
      logic signed [15:0] b_re;
      logic signed [15:0] b_im;
      logic               scale;
      logic [3:0]         tag;
   } item_t;

   item_t cur;
   bit    have;
   bit    held;
   int    tag_ctr;
   item_t sb[$];

   function automatic logic [67:0] ref_out(input item_t it);
      int sr, si, dr, di;
      sr = int'(it.a_re) + int'(it.b_re);
      si = int'(it.a_im) + int'(it.b_im);
      dr = int'(it.a_re) - int'(it.b_re);
      di = int'(it.a_im) - int'(it.b_im);
      if (it.scale) begin
         sr = (sr + 1) >>> 1;
         si = (si + 1) >>> 1;
         dr = (dr + 1) >>> 1;
         di = (di + 1) >>> 1;
      end
      return {sr[16:0], si[16:0], dr[16:0], di[16:0]};
   endfunction

   task automatic gen_item();
      cur.a_re  = 16'($urandom());
      cur.a_im  = 16'($urandom());
      cur.b_re  = 16'($urandom());
      cur.b_im  = 16'($urandom());
      cur.scale = 1'($urandom_range(1));
      cur.tag   = tag_ctr[3:0];
      tag_ctr++;
      have = 1'b1;
   endtask

   // A stalled item stays on the bus unchanged until it is accepted.
   task automatic drive_in(input bit want);
      if (held) begin
         bus16.in_valid = 1'b1;
      end else if (want) begin
         if (!have) gen_item();
         bus16.in_valid = 1'b1;
      end else begin
         bus16.in_valid = 1'b0;
      end
      bus16.a_re   = cur.a_re;
      bus16.a_im   = cur.a_im;
      bus16.b_re   = cur.b_re;
      bus16.b_im   = cur.b_im;
      bus16.scale  = cur.scale;
      bus16.tag_in = cur.tag;
   endtask

   task automatic note_in(output bit fired);
      fired = bus16.in_valid && bus16.in_ready;
      if (fired) begin
         sb.push_back(cur);
         have = 1'b0;
      end
      held = bus16.in_valid && !bus16.in_ready;
   endtask

   task automatic run_stream(input string name, input int n, input int pv, input int pr,
                             output int first_c, output int last_c);
      int target;
      int sent;
      int recv;
      int cyc;
      bit fired;
      bit prev_stall;
      logic [67:0] prev_data;
      logic [3:0]  prev_tag;
      logic [67:0] exp;
      target = n + sb.size();
      sent = 0;
      recv = 0;
      cyc = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      prev_tag = '0;
      first_c = -1;
      last_c = -1;
      while (recv < target && cyc < n * 10 + 100) begin
         @(negedge clk);
         drive_in(sent < n && $urandom_range(99) < pv);
         bus16.out_ready = ($urandom_range(99) < pr);
         #1;
         checks++;
         if (!bus16.in_ready && sb.size() < 2) begin
            errors++;
            $display("FAIL %s in_ready: got 0 with %0d in flight, want 1", name, sb.size());
         end
         if (prev_stall) begin
            checks++;
            if (!bus16.out_valid ||
                {bus16.sum_re, bus16.sum_im, bus16.dif_re, bus16.dif_im} !== prev_data ||
                bus16.tag_out !== prev_tag) begin
               errors++;
               $display("FAIL %s stall_hold: got v=%0b %h tag %0d want v=1 %h tag %0d", name,
                        bus16.out_valid, {bus16.sum_re, bus16.sum_im, bus16.dif_re, bus16.dif_im},
                        bus16.tag_out, prev_data, prev_tag);
            end
         end
         if (bus16.out_valid && bus16.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL %s extra_output: got output tag %0d, want none", name, bus16.tag_out);
            end else begin
               exp = ref_out(sb[0]);
               if ({bus16.sum_re, bus16.sum_im, bus16.dif_re, bus16.dif_im} !== exp ||
                   bus16.tag_out !== sb[0].tag) begin
                  errors++;
                  $display("FAIL %s data #%0d: got %h tag %0d want %h tag %0d", name, recv,
                           {bus16.sum_re, bus16.sum_im, bus16.dif_re, bus16.dif_im},
                           bus16.tag_out, exp, sb[0].tag);
               end
               void'(sb.pop_front());
            end
            recv++;
            if (first_c < 0) first_c = cyc;
            last_c = cyc;
         end
         note_in(fired);
         if (fired) sent++;
         prev_stall = bus16.out_valid && !bus16.out_ready;
         prev_data  = {bus16.sum_re, bus16.sum_im, bus16.dif_re, bus16.dif_im};
         prev_tag   = bus16.tag_out;
         cyc++;
      end
      bus16.in_valid = 1'b0;
      checks++;
      if (recv != target) begin
         errors++;
         $display("FAIL %s drain_count: got %0d outputs want %0d", name, recv, target);
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (bus16.out_valid !== 1'b0 || bus2.out_valid !== 1'b0 ||
          {bus16.sum_re, bus16.sum_im, bus16.dif_re, bus16.dif_im, bus16.tag_out} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got v16=%0b v2=%0b data=%h want 0", bus16.out_valid,
                  bus2.out_valid, {bus16.sum_re, bus16.sum_im, bus16.dif_re, bus16.dif_im});
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus16.in_ready !== 1'b1 || bus2.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %0b/%0b want 1/1", bus2.in_ready, bus16.in_ready);
      end
   endtask

   task automatic test_w2_basic();
      @(negedge clk);
      bus2.a_re = -2'sd2; bus2.a_im = 2'sd1;
      bus2.b_re = 2'sd1;  bus2.b_im = -2'sd2;
      bus2.scale = 1'b0; bus2.tag_in = 4'd9;
      bus2.in_valid = 1'b1; bus2.out_ready = 1'b1;
      @(negedge clk);
      bus2.in_valid = 1'b0;
      #1;
      checks++;
      if (bus2.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL w2_basic early_valid: got %0b want 0", bus2.out_valid);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus2.out_valid !== 1'b1 ||
          {bus2.sum_re, bus2.sum_im, bus2.dif_re, bus2.dif_im} !== 12'b111_111_101_011 ||
          bus2.tag_out !== 4'd9) begin
         errors++;
         $display("FAIL w2_basic result: got v=%0b %b tag %0d want v=1 111111101011 tag 9",
                  bus2.out_valid, {bus2.sum_re, bus2.sum_im, bus2.dif_re, bus2.dif_im}, bus2.tag_out);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus2.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL w2_basic drain: got out_valid %0b want 0", bus2.out_valid);
      end
   endtask

   task automatic test_w2_extremes();
      @(negedge clk);
      bus2.a_re = -2'sd2; bus2.a_im = -2'sd2;
      bus2.b_re = -2'sd2; bus2.b_im = 2'sd1;
      bus2.scale = 1'b0; bus2.tag_in = 4'd3;
      bus2.in_valid = 1'b1; bus2.out_ready = 1'b1;
      @(negedge clk);
      bus2.scale = 1'b1; bus2.tag_in = 4'd4;
      @(negedge clk);
      bus2.in_valid = 1'b0;
      #1;
      checks++;
      if (bus2.out_valid !== 1'b1 ||
          {bus2.sum_re, bus2.sum_im, bus2.dif_re, bus2.dif_im} !== 12'b100_111_000_101 ||
          bus2.tag_out !== 4'd3) begin
         errors++;
         $display("FAIL w2_ext full: got v=%0b %b tag %0d want v=1 100111000101 tag 3",
                  bus2.out_valid, {bus2.sum_re, bus2.sum_im, bus2.dif_re, bus2.dif_im}, bus2.tag_out);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus2.out_valid !== 1'b1 ||
          {bus2.sum_re, bus2.sum_im, bus2.dif_re, bus2.dif_im} !== 12'b110_000_000_111 ||
          bus2.tag_out !== 4'd4) begin
         errors++;
         $display("FAIL w2_ext scaled: got v=%0b %b tag %0d want v=1 110000000111 tag 4",
                  bus2.out_valid, {bus2.sum_re, bus2.sum_im, bus2.dif_re, bus2.dif_im}, bus2.tag_out);
      end
   endtask

   task automatic test_back_to_back();
      int f, l;
      sb.delete(); have = 1'b0; held = 1'b0; tag_ctr = 0;
      run_stream("b2b", 20, 100, 100, f, l);
      checks++;
      if (l - f + 1 != 20) begin
         errors++;
         $display("FAIL b2b span: got %0d cycles want 20", l - f + 1);
      end
   endtask

   task automatic test_backpressure();
      int acc;
      int f, l;
      bit fired;
      logic [67:0] snap;
      logic [3:0]  snap_tag;
      sb.delete(); have = 1'b0; held = 1'b0; tag_ctr = 0;
      acc = 0; snap = '0; snap_tag = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive_in(1'b1);
         bus16.out_ready = 1'b0;
         #1;
         if (i >= 2) begin
            checks++;
            if (bus16.in_ready !== 1'b0) begin
               errors++;
               $display("FAIL bp in_ready cycle %0d: got %0b want 0", i, bus16.in_ready);
            end
         end
         if (i == 2) begin
            snap = {bus16.sum_re, bus16.sum_im, bus16.dif_re, bus16.dif_im};
            snap_tag = bus16.tag_out;
            checks++;
            if (bus16.out_valid !== 1'b1 || snap !== ref_out(sb[0])) begin
               errors++;
               $display("FAIL bp first_out: got v=%0b %h want v=1 %h", bus16.out_valid, snap,
                        ref_out(sb[0]));
            end
         end else if (i > 2) begin
            checks++;
            if (bus16.out_valid !== 1'b1 || bus16.tag_out !== snap_tag ||
                {bus16.sum_re, bus16.sum_im, bus16.dif_re, bus16.dif_im} !== snap) begin
               errors++;
               $display("FAIL bp hold cycle %0d: got v=%0b %h want v=1 %h", i, bus16.out_valid,
                        {bus16.sum_re, bus16.sum_im, bus16.dif_re, bus16.dif_im}, snap);
            end
         end
         note_in(fired);
         if (fired) acc++;
      end
      checks++;
      if (acc != 2) begin
         errors++;
         $display("FAIL bp accepted: got %0d want 2", acc);
      end
      run_stream("bp_release", 3, 100, 100, f, l);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL bp leftover: got %0d pending want 0", sb.size());
      end
   endtask

   task automatic test_random();
      int f, l;
      sb.delete(); have = 1'b0; held = 1'b0;
      run_stream("rand", 1000, 50, 50, f, l);
   endtask

   task automatic test_reset_mid();
      bit fired;
      logic [67:0] exp;
      sb.delete(); have = 1'b0; held = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         drive_in(1'b1);
         bus16.out_ready = 1'b0;
         #1;
         note_in(fired);
      end
      @(negedge clk);
      bus16.in_valid = 1'b0;
      #1;
      checks++;
      if (bus16.out_valid !== 1'b1 || bus16.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid full: got v=%0b rdy=%0b want v=1 rdy=0", bus16.out_valid,
                  bus16.in_ready);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus16.out_valid !== 1'b0 || bus16.tag_out !== 4'd0 ||
          {bus16.sum_re, bus16.sum_im, bus16.dif_re, bus16.dif_im} !== '0) begin
         errors++;
         $display("FAIL rst_mid clear: got v=%0b %h want v=0 all zero", bus16.out_valid,
                  {bus16.sum_re, bus16.sum_im, bus16.dif_re, bus16.dif_im});
      end
      sb.delete(); have = 1'b0; held = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus16.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid in_ready: got %0b want 1", bus16.in_ready);
      end
      @(negedge clk);
      drive_in(1'b1);
      bus16.out_ready = 1'b1;
      #1;
      note_in(fired);
      exp = ref_out(cur);
      @(negedge clk);
      bus16.in_valid = 1'b0;
      #1;
      checks++;
      if (bus16.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid early: got out_valid %0b want 0", bus16.out_valid);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus16.out_valid !== 1'b1 || bus16.tag_out !== cur.tag ||
          {bus16.sum_re, bus16.sum_im, bus16.dif_re, bus16.dif_im} !== exp) begin
         errors++;
         $display("FAIL rst_mid latency: got v=%0b %h want v=1 %h", bus16.out_valid,
                  {bus16.sum_re, bus16.sum_im, bus16.dif_re, bus16.dif_im}, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.scale = 1'b0; bus2.tag_in = '0;
      bus2.a_re = '0; bus2.a_im = '0; bus2.b_re = '0; bus2.b_im = '0;
      bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.scale = 1'b0; bus16.tag_in = '0;
      bus16.a_re = '0; bus16.a_im = '0; bus16.b_re = '0; bus16.b_im = '0;
      have = 1'b0; held = 1'b0; tag_ctr = 0;
      cur = '{a_re: '0, a_im: '0, b_re: '0, b_im: '0, scale: 1'b0, tag: '0};

      test_reset();
      test_w2_basic();
      test_w2_extremes();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_mid();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cplx_addsub_pipe.md
Name: cplx_addsub_pipe

Overview:
- Parametrised, pipelined complex add/subtract unit: the radix-2 butterfly core of the 8-point FFT/IFFT datapath.
- Accepts one complex pair (A, B) per transaction and returns both A+B and A-B, at full precision or scaled by 1/2 with rounding.
- Valid/ready handshakes on both sides.
- Sits between the twiddle multiplier output and the stage reorder buffer.

Parameters:
- W, 16, signed width of each real/imag input component (minimum 2).
- TAG_W, 4, width of a sideband tag carried unchanged alongside the data (minimum 1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  unit accepts input this cycle.
- a_re, a_im  in  W  signed component A.
- b_re, b_im  in  W  signed component B.
- scale  in  1  per-transaction: 1 = halve results with rounding, 0 = full precision.
- tag_in  in  TAG_W  sideband tag.
- out_valid  out  1  output transaction present.
- out_ready  in  1  downstream accepts output.
- sum_re, sum_im  out  W+1  signed A+B, after optional scaling.
- dif_re, dif_im  out  W+1  signed A-B, after optional scaling.
- tag_out  out  TAG_W  tag of the current output transaction.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs and internal registers go to 0 asynchronously. in_ready reads 1 once reset deasserts, since both stages are empty.
- Handshakes: a transfer occurs on a rising edge where valid && ready.
  - Producer must hold inputs stable while in_valid=1 && in_ready=0.
  - out_* holds stable while out_valid=1 && out_ready=0.
- Pipeline: two stages, S1 and S2, each with a valid flag.
  - S1 registers the four W+1-bit sign-extended results (re/im sum and diff), plus scale and tag.
  - S2 registers the scaled results, and its valid flag drives out_valid.
  - Latency: 2 cycles from input accept to out_valid when unstalled. Throughput is 1 transaction per cycle.
- Advance rules:
  - S2 loads when (!s2_valid || out_ready).
  - S1 moves to S2 whenever S2 loads.
  - S1 loads from the input when (!s1_valid || S2 loads).
  - in_ready = !s1_valid || !s2_valid || out_ready. Bubbles collapse, so a full stall needs both stages occupied.
  - Valid flags clear when the stage drains and is not refilled.
- Arithmetic:
  - Sums and differences are computed on sign-extended W+1-bit operands. No overflow is possible.
  - scale=0: output = x.
  - scale=1: output = (x + 1) >>> 1, evaluated in W+2 bits and truncated to W+1 bits. This is arithmetic shift with round-half-up, and the result always fits.
- Simultaneous events:
  - Input accept plus output consume in the same cycle with both stages full: both stages advance and no data is lost or duplicated.
  - out_ready=1 with out_valid=0 has no effect.
- Reset mid-operation: all in-flight transactions are discarded immediately. out_valid drops asynchronously, with no partial output.
- Tag is purely sideband. It is never reordered and stays aligned with its data.

Test Plan:
- W=2, scale=0: a=(-2,1), b=(1,-2), out_ready=1 -> exactly 2 cycles later out_valid=1 with sum=(-1,-1), dif=(-3,3), tag_out=tag_in.
- W=2, extremes, scale=0: a=(-2,-2), b=(-2,1) -> sum=(-4,-1), dif=(0,-3). With scale=1: sum=(-2,0), dif=(0,-1), since (-1+1)>>>1=0 and (-3+1)>>>1=-1.
- W=16, back-to-back stream of 20 random transactions with tags 0..15 wrapping, out_ready=1 -> 20 outputs on consecutive cycles, in order, matching the reference model.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 transactions accepted, then in_ready=0. out_* stays stable throughout. On release, no loss or duplication.
- Random in_valid and out_ready at 50% each, 1000 transactions with mixed scale -> scoreboard matches in order, and in_ready is never 0 when a stage is empty.
- Assert rst_n low mid-stream with both stages full -> out_valid=0 and outputs=0 immediately. After release, in_ready=1 and the first new input appears 2 cycles after accept.
